// File: rtl/nrf_spi_burst_master.sv
// nRF24L01 SPI mode-0 burst master: one command byte plus up to MAX_LEN
// payload bytes per chip-select frame, with tx handshake and rx strobe.
module nrf_spi_burst_master #(
    parameter int CLK_DIV = 5,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic             clk_in,
    input  logic             key0_rst,
    input  logic             start,
    input  logic [7:0]       cmd,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [7:0]       status,
    output logic             busy,
    output logic             done,
    output logic             csn,
    output logic             sck,
    output logic             mosi,
    input  logic             miso
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_CMD,
        FETCH,
        SHIFT_DATA,
        HOLD
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]    cnt;
    logic             phase;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic [LEN_W-1:0] rem;

    logic       cnt_last;
    logic       shifting;
    logic       sample;
    logic       bit_end;
    logic       byte_end;
    logic [7:0] rx_nx;
    logic [7:0] rx_byte;

    assign cnt_last = (cnt == CNT_LAST);
    assign shifting = (state == SHIFT_CMD) || (state == SHIFT_DATA);
    assign sample   = shifting && phase && (cnt == '0);
    assign bit_end  = shifting && phase && cnt_last;
    assign byte_end = bit_end && (bit_cnt == 3'd7);
    assign rx_nx    = {rx_sh[6:0], miso};
    // with CLK_DIV=1 the last sample and the byte end share a cycle
    assign rx_byte  = sample ? rx_nx : rx_sh;

    assign csn      = !(state inside {SETUP, SHIFT_CMD, FETCH, SHIFT_DATA});
    assign sck      = shifting && phase;
    assign mosi     = !csn && tx_sh[7];
    assign tx_ready = (state == FETCH);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (!key0_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = SETUP;
            end
            SETUP: begin
                if (cnt_last) state_nx = SHIFT_CMD;
            end
            SHIFT_CMD: begin
                if (byte_end) state_nx = (rem == '0) ? HOLD : FETCH;
            end
            FETCH: begin
                if (tx_valid) state_nx = SHIFT_DATA;
            end
            SHIFT_DATA: begin
                if (byte_end) state_nx = (rem == LEN_W'(1)) ? HOLD : FETCH;
            end
            HOLD: begin
                if (cnt_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!key0_rst) begin
            cnt      <= '0;
            phase    <= 1'b0;
            bit_cnt  <= 3'd0;
            tx_sh    <= 8'h00;
            rx_sh    <= 8'h00;
            rem      <= '0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            status   <= 8'h00;
            done     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh   <= cmd;
                        rem     <= (len > LEN_MAX) ? LEN_MAX : len;
                        cnt     <= '0;
                        phase   <= 1'b0;
                        bit_cnt <= 3'd0;
                    end
                end
                SETUP: begin
                    cnt <= cnt_last ? '0 : cnt + CW'(1);
                end
                SHIFT_CMD, SHIFT_DATA: begin
                    if (sample) rx_sh <= rx_nx;
                    if (cnt_last) begin
                        cnt   <= '0;
                        phase <= ~phase;
                        // mosi advances only as sck falls
                        if (phase) begin
                            tx_sh   <= {tx_sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                    if (byte_end) begin
                        if (state == SHIFT_CMD) begin
                            status <= rx_byte;
                        end else begin
                            rx_data  <= rx_byte;
                            rx_valid <= 1'b1;
                            rem      <= rem - LEN_W'(1);
                        end
                    end
                end
                FETCH: begin
                    if (tx_valid) begin
                        tx_sh   <= tx_data;
                        cnt     <= '0;
                        phase   <= 1'b0;
                        bit_cnt <= 3'd0;
                    end
                end
                HOLD: begin
                    if (cnt_last) begin
                        cnt  <= '0;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nrf_spi_burst_master.sv
// Self-checking bench for nrf_spi_burst_master: table of frames with a
// mode-0 slave model and queue scoreboards for mosi bytes and rx bytes.
module tb_nrf_spi_burst_master;
    logic       clk_in = 1'b0;
    logic       key0_rst;
    logic       start;
    logic [7:0] cmd;
    logic [5:0] len;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] status;
    logic       busy;
    logic       done;
    logic       csn;
    logic       sck;
    logic       mosi;
    logic       miso;

    always #5 clk_in = ~clk_in;

    nrf_spi_burst_master #(
        .CLK_DIV(2),
        .MAX_LEN(32),
        .LEN_W  (6)
    ) dut (
        .clk_in  (clk_in),
        .key0_rst(key0_rst),
        .start   (start),
        .cmd     (cmd),
        .len     (len),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .status  (status),
        .busy    (busy),
        .done    (done),
        .csn     (csn),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso)
    );

    typedef struct {
        logic [7:0] cmd;
        logic [5:0] len;
        logic [7:0] tx_byte;
        logic [7:0] st;
        logic [7:0] rx_base;
        bit         stall;
        bit         bstart;
        bit         b2b;
        int         edges;
        int         csn_low;
    } vec_t;

    vec_t vecs[6];

    logic [7:0] slv_mem[34];
    logic [5:0] s_idx;
    logic [2:0] s_bit;
    logic       s_prev;

    logic [7:0] rx_q[$];
    logic [7:0] mosi_q[$];

    int checks = 0;
    int errors = 0;
    int n_edges, n_csn, n_done, n_hs, n_rxv, n_viol, stall_ctr, nb;
    logic [7:0] mbits;
    logic ps;

    // mode-0 slave: next bit presented after each sck falling edge
    always @(negedge clk_in) begin
        if (csn) begin
            s_idx <= 6'd0;
            s_bit <= 3'd0;
        end else if (s_prev && !sck) begin
            if (s_bit == 3'd7) begin
                s_bit <= 3'd0;
                s_idx <= s_idx + 6'd1;
            end else begin
                s_bit <= s_bit + 3'd1;
            end
        end
        s_prev <= sck;
    end

    assign miso = slv_mem[s_idx][3'd7 - s_bit];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int eff;
        int cyc;
        bit got_done;
        logic [7:0] e;
        eff = (v.len > 6'd32) ? 32 : int'(v.len);
        slv_mem[0] = v.st;
        for (int i = 0; i < 33; i++) slv_mem[i+1] = v.rx_base + 8'(i);
        rx_q.delete();
        mosi_q.delete();
        for (int i = 0; i < eff; i++) rx_q.push_back(v.rx_base + 8'(i));
        mosi_q.push_back(v.cmd);
        for (int i = 0; i < eff; i++) mosi_q.push_back(v.tx_byte);
        n_edges = 0; n_csn = 0; n_done = 0; n_hs = 0;
        n_rxv = 0; n_viol = 0; stall_ctr = 0; nb = 0;
        mbits = 8'h00;
        ps = sck;
        cmd = v.cmd;
        len = v.len;
        tx_data = v.tx_byte;
        start = 1'b1;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            @(negedge clk_in);
            cyc++;
            if (cyc == 1) begin
                chk("busy_after_start", busy, 1);
                chk("csn_after_start", csn, 0);
            end
            if (!csn) n_csn++;
            if (csn && mosi) n_viol++;
            if (sck && !ps) begin
                n_edges++;
                mbits = {mbits[6:0], mosi};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (mosi_q.size() > 0) begin
                        chk("mosi_byte", mbits, mosi_q.pop_front());
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL mosi_extra actual=%02h required=none",
                                 mbits);
                    end
                end
            end
            ps = sck;
            if (rx_valid) begin
                n_rxv++;
                if (rx_q.size() > 0) begin
                    e = rx_q.pop_front();
                    chk("rx_data", rx_data, e);
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL rx_extra actual=%02h required=none",
                             rx_data);
                end
            end
            if (done) begin
                n_done++;
                got_done = 1'b1;
                chk("busy_at_done", busy, 0);
            end
            start = v.bstart && (cyc == 20);
            if (v.stall && n_hs == 1 && tx_ready && stall_ctr < 10) begin
                tx_valid = 1'b0;
                stall_ctr++;
                if (csn || sck) n_viol++;
            end else begin
                tx_valid = 1'b1;
            end
            if (tx_valid && tx_ready) n_hs++;
        end
        chk("frame_done_seen", got_done, 1);
        chk("done_count", n_done, 1);
        chk("sck_rising_edges", n_edges, v.edges);
        chk("csn_low_cycles", n_csn, v.csn_low);
        chk("status", status, v.st);
        chk("tx_handshakes", n_hs, eff);
        chk("rx_valid_pulses", n_rxv, eff);
        chk("rx_q_left", rx_q.size(), 0);
        chk("mosi_q_left", mosi_q.size(), 0);
        chk("mosi_csn_stall_viol", n_viol, 0);
        if (v.stall) chk("stall_cycles", stall_ctr, 10);
    endtask

    initial begin
        int cyc;
        int dcnt;
        vecs[0] = '{8'hFF, 6'd0,  8'h00, 8'h0E, 8'h00, 1'b0, 1'b0, 1'b0, 8,   34};
        vecs[1] = '{8'h20, 6'd1,  8'h0B, 8'h0E, 8'hA0, 1'b0, 1'b0, 1'b0, 16,  67};
        vecs[2] = '{8'h61, 6'd32, 8'hFF, 8'h0E, 8'h00, 1'b0, 1'b0, 1'b0, 264, 1090};
        vecs[3] = '{8'hA0, 6'd2,  8'h5A, 8'h07, 8'h30, 1'b1, 1'b0, 1'b0, 24,  110};
        vecs[4] = '{8'h61, 6'd40, 8'hC3, 8'h0E, 8'h10, 1'b0, 1'b1, 1'b0, 264, 1090};
        vecs[5] = '{8'hE1, 6'd3,  8'h96, 8'h4A, 8'h80, 1'b0, 1'b0, 1'b1, 32,  133};
        for (int i = 0; i < 34; i++) slv_mem[i] = 8'h00;
        key0_rst = 1'b0;
        start = 1'b0;
        cmd = 8'h00;
        len = 6'd0;
        tx_data = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_csn", csn, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_status", status, 0);
        chk("rst_rx_data", rx_data, 0);
        key0_rst = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 6; i++) begin
            if (!vecs[i].b2b) repeat (2) @(negedge clk_in);
            run_frame(vecs[i]);
        end

        repeat (2) @(negedge clk_in);
        slv_mem[0] = 8'h0E;
        cmd = 8'hFF;
        len = 6'd0;
        start = 1'b1;
        n_edges = 0;
        ps = sck;
        cyc = 0;
        while (n_edges < 5 && cyc < 500) begin
            @(negedge clk_in);
            start = 1'b0;
            if (sck && !ps) n_edges++;
            ps = sck;
            cyc++;
        end
        chk("rst_reach_edge5", n_edges, 5);
        key0_rst = 1'b0;
        @(negedge clk_in);
        chk("midrst_csn", csn, 1);
        chk("midrst_sck", sck, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mosi", mosi, 0);
        chk("midrst_tx_ready", tx_ready, 0);
        chk("midrst_status", status, 0);
        chk("midrst_rx_data", rx_data, 0);
        dcnt = 0;
        if (done) dcnt++;
        repeat (2) begin
            @(negedge clk_in);
            if (done) dcnt++;
        end
        key0_rst = 1'b1;
        repeat (6) begin
            @(negedge clk_in);
            if (done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);
        run_frame(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nrf_spi_burst_master.md
NRF_SPI_BURST_MASTER -- requirements
Module: nrf_spi_burst_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5: SCK half-period in clk_in cycles (SCK = clk_in/(2*CLK_DIV)); legal range >= 1.
REQ-002 SHALL have parameter MAX_LEN, default 32: maximum payload bytes after the command byte.
REQ-003 SHALL have parameter LEN_W, default 6: width of len; LEN_W >= clog2(MAX_LEN+1).
REQ-004 clk_in  in  1  single system clock; all logic on its rising edge.
REQ-005 key0_rst  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  frame request; sampled only in IDLE.
REQ-007 cmd  in  8  nRF24L01 command byte, latched on accepted start.
REQ-008 len  in  LEN_W  payload byte count, latched on accepted start.
REQ-009 tx_data  in  8  next payload byte to send.
REQ-010 tx_valid  in  1  tx_data valid.
REQ-011 tx_ready  out  1  engine requests next payload byte.
REQ-012 rx_data  out  8  last received payload byte.
REQ-013 rx_valid  out  1  one-cycle pulse, rx_data updated.
REQ-014 status  out  8  byte shifted in during the command byte (nRF STATUS).
REQ-015 busy  out  1  high from accepted start until done.
REQ-016 done  out  1  one-cycle pulse at frame end.
REQ-017 csn  out  1  chip select, active-low.
REQ-018 sck  out  1  SPI clock.
REQ-019 mosi  out  1  master data out.
REQ-020 miso  in  1  slave data in.

Function
REQ-021 SHALL implement SPI mode 0: sck idle low, MSB first, mosi stable across each rising edge, miso sampled on the clk_in cycle in which sck rises.
REQ-022 SHALL sequence states IDLE -> SETUP -> SHIFT_CMD -> (FETCH -> SHIFT_DATA)*len -> HOLD -> IDLE.
REQ-023 IDLE: start=1 latches cmd, len; sets busy=1, csn=0 the next cycle; enters SETUP.
REQ-024 SETUP: csn low, sck low, mosi = cmd[7], for CLK_DIV cycles.
REQ-025 Each bit: sck low CLK_DIV cycles with mosi driven, then sck high CLK_DIV cycles; 16*CLK_DIV cycles per byte.
REQ-026 After SHIFT_CMD bit 0: status updated with the 8 sampled bits; status holds until next frame's command byte completes.
REQ-027 len=0: HOLD directly after SHIFT_CMD; tx_ready never asserted.
REQ-028 len > MAX_LEN: clamped to MAX_LEN at latch.
REQ-029 FETCH: tx_ready=1, sck=0, csn=0; on tx_valid&&tx_ready the byte is latched, tx_ready drops next cycle, SHIFT_DATA begins; minimum 1 cycle in FETCH.
REQ-030 tx_valid low in FETCH: stall indefinitely, csn held low, no sck edges.
REQ-031 After each SHIFT_DATA byte: rx_data updated and rx_valid pulses 1 cycle, same cycle the FSM leaves SHIFT_DATA.
REQ-032 HOLD: sck low, csn high for CLK_DIV cycles; then done=1 for 1 cycle, busy=0, return to IDLE.
REQ-033 start during busy SHALL be ignored; start in the done cycle is accepted.
REQ-034 mosi SHALL be 0 whenever csn=1.
REQ-035 Unstalled frame: csn low for CLK_DIV + 16*CLK_DIV*(len+1) + len cycles.

Reset
REQ-036 key0_rst=0 at a clock edge: next cycle csn=1, sck=0, mosi=0, tx_ready=0, rx_valid=0, done=0, busy=0, status=0x00, rx_data=0x00, FSM=IDLE.
REQ-037 Reset mid-frame SHALL abort without a done pulse; a start after release proceeds normally.

Verification (CLK_DIV=2, MAX_LEN=32)
REQ-038 NOP: cmd=0xFF, len=0, slave returns 0x0E -> 8 sck rising edges, mosi 11111111, status=0x0E, csn low 34 cycles, one done.
REQ-039 W_REGISTER: cmd=0x20, len=1, tx_data=0x0B always valid -> mosi 0x20 then 0x0B, 16 rising edges, one handshake, one rx_valid, csn low 67 cycles.
REQ-040 R_RX_PAYLOAD: cmd=0x61, len=32, slave sends 0x00..0x1F -> 32 rx_valid pulses with rx_data 0x00..0x1F in order, 264 rising edges.
REQ-041 Stall: len=2, tx_valid withheld 10 cycles before byte 2 -> csn stays 0, sck 0 throughout stall, total 24 rising edges, frame completes.
REQ-042 Reset after 5th cmd rising edge -> next cycle csn=1, sck=0, busy=0, no done; new NOP frame then passes REQ-038.
REQ-043 start pulsed while busy -> ignored, exactly one done; len=40 -> exactly 32 payload bytes transferred.
